// File: rtl/sr_latch_driver_if.sv
// Command handshake and latch strobe/readback bundle for sr_latch_driver.
// The slave modport is the driver. The master modport is its environment:
// the controller that issues commands and the external latch that returns
// Q/Q_bar.
interface sr_latch_driver_if;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic S_bar;
  logic R_bar;
  logic q_in;
  logic q_bar_in;
  logic done;
  logic err;
  logic busy;

  modport master (
    output cmd_valid, cmd_set, q_in, q_bar_in,
    input  cmd_ready, S_bar, R_bar, done, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_set, q_in, q_bar_in,
    output cmd_ready, S_bar, R_bar, done, err, busy
  );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives the active-low S_bar/R_bar inputs of an external
// NAND SR latch. For each accepted command it pulses exactly one strobe low,
// waits for the latch to settle, then reads Q/Q_bar back and reports done/err.
// The strobe next-values are derived from a single command bit, so the
// forbidden S_bar=R_bar=0 input cannot be produced.
// Optional feature macro: SR_SKIP_REDUNDANT_EN. When it is defined, a command
// whose target state is already held by the latch skips the pulse and settle
// phases and goes straight to readback.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

  // Each interval counts down from N-1 to 0. The transition happens at the
  // edge where the counter reads 0, which is exactly N edges after the load.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_q, cmd_d;
  logic             s_bar_q, s_bar_d;
  logic             r_bar_q, r_bar_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic accept;
  logic skip;
  logic cnt_zero;
  logic readback_bad;

  assign accept   = bus.cmd_valid && ready_q;
  assign cnt_zero = (cnt_q == '0);
  // An invalid latch state (q_in == q_bar_in) always fails one of the two
  // terms, so it is always flagged.
  assign readback_bad = (bus.q_in != cmd_q) || (bus.q_bar_in != ~cmd_q);

`ifdef SR_SKIP_REDUNDANT_EN
  // The latch already holds the requested value, so no strobe is needed.
  assign skip = (bus.q_in == bus.cmd_set) && (bus.q_bar_in == ~bus.cmd_set);
`else
  assign skip = 1'b0;
`endif

  // State register and registered outputs.
  // NOTE: the strobes reset high asynchronously, so the latch sees no set or
  // reset while rst_n is low, even in the middle of a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      s_bar_q <= 1'b1;
      r_bar_q <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignment, so every register
      // samples values from before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      s_bar_q <= s_bar_d;
      r_bar_q <= r_bar_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: IDLE -> PULSE -> SETTLE -> CHECK -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = skip ? CHECK : PULSE;
      PULSE:   if (cnt_zero) state_d = SETTLE;
      SETTLE:  if (cnt_zero) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, the counter and the command bit.
  always_comb begin
    // NOTE: every signal gets a default before the case statement; a branch
    // that missed an assignment would otherwise infer a latch.
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    s_bar_d = 1'b1;
    r_bar_d = 1'b1;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          cmd_d   = bus.cmd_set;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          if (!skip) begin
            s_bar_d = ~bus.cmd_set;
            r_bar_d = bus.cmd_set;
            cnt_d   = PULSE_LOAD;
          end
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          cnt_d = SETTLE_LOAD;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          s_bar_d = ~cmd_q;
          r_bar_d = cmd_q;
        end
      end
      SETTLE: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
      end
      CHECK: begin
        done_d  = 1'b1;
        err_d   = readback_bad;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.S_bar     = s_bar_q;
  assign bus.R_bar     = r_bar_q;
  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous initiator that drives the active-low set/reset inputs (S_bar, R_bar) of an external NAND SR latch.
- Accepts set/reset commands over a valid/ready handshake and generates a timed low pulse on exactly one strobe.
- Waits a settle interval, then reads back Q/Q_bar and reports done plus a mismatch error.
- Sits between control logic and latch-based status/flag storage; guarantees the forbidden S_bar=R_bar=0 input is never produced.

Parameters:
- PULSE_CYCLES, 4, number of clock periods the selected strobe is held low (legal range 1 to 2^CNT_W-1)
- SETTLE_CYCLES, 2, number of clock periods both strobes stay high before readback (legal range 1 to 2^CNT_W-1)
- CNT_W, 8, width of the internal interval counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_set  input  1  1 = set latch (Q=1), 0 = reset latch (Q=0); qualified by cmd_valid
- cmd_ready  output  1  block can accept a command
- S_bar  output  1  active-low set strobe to latch
- R_bar  output  1  active-low reset strobe to latch
- q_in  input  1  latch Q readback
- q_bar_in  input  1  latch Q_bar readback
- done  output  1  one-cycle completion pulse
- err  output  1  readback mismatch flag for the last completed command
- busy  output  1  command in progress

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; it acts immediately on assertion, independent of clk.
- All outputs are registered.
- Reset values: S_bar=1, R_bar=1, cmd_ready=0, done=0, err=0, busy=0, state=IDLE, counter=0.
- cmd_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - cmd_ready=1.
  - At the edge with cmd_valid&&cmd_ready (T0): latch cmd_set into cmd_reg, clear err, set busy=1, set cmd_ready=0, load counter, go to PULSE.
  - In the same edge, drive S_bar=0 if cmd_set=1, otherwise drive R_bar=0.
- PULSE:
  - The selected strobe stays low for exactly PULSE_CYCLES periods, starting at T0.
  - At edge T0+PULSE_CYCLES, both strobes return to 1, the counter reloads, and the FSM goes to SETTLE.
- SETTLE:
  - Both strobes are high for exactly SETTLE_CYCLES periods.
  - At the end of the interval the FSM goes to CHECK.
- CHECK (one cycle):
  - q_in and q_bar_in are sampled at edge T0+PULSE_CYCLES+SETTLE_CYCLES+1.
  - At that edge: done=1 for one cycle; err=1 if q_in!=cmd_reg or q_bar_in!=~cmd_reg; busy=0; cmd_ready=1; go to IDLE.
- Latency: done is asserted in the period beginning at T0+PULSE_CYCLES+SETTLE_CYCLES+1. With the default parameters this is T0+7.
- Throughput:
  - A new command may be accepted in the same cycle done is high (back-to-back operation).
  - Its strobe goes low at that acceptance edge.
- err is held until the next command is accepted, then cleared at that accept edge.
- Invariant: S_bar and R_bar are never 0 simultaneously, in any state or during reset.
- cmd_valid is ignored while cmd_ready=0. cmd_set is sampled only at the accept edge.
- Reset mid-operation:
  - Strobes return high immediately (asynchronously).
  - The command is dropped; no done pulse is produced for it.
- q_in==q_bar_in at readback (for example, an invalid latch state) is always flagged as err=1.

Optional Feature:
- Macro: SR_SKIP_REDUNDANT_EN.
- Defined:
  - At the accept edge, if q_in==cmd_set and q_bar_in==~cmd_set, no strobe is pulsed and the FSM goes directly to CHECK.
  - done then follows at T0+1, with err computed normally.
- Undefined:
  - Every accepted command pulses its strobe, regardless of the current latch state.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> S_bar=1, R_bar=1, done=0, err=0 throughout reset; cmd_ready=1 one edge after release.
- cmd_set=1 accepted at T0 with a NAND latch model on the bench -> S_bar=0 for exactly 4 cycles, R_bar=1 throughout, done=1 at T0+7, err=0, q_in=1.
- cmd_set=0 immediately after a set completes (back-to-back, accepted in the done cycle) -> R_bar=0 for 4 cycles, S_bar=1, Q=0, done=1 at T0+7, err=0.
- Latch model stuck at Q=0 and cmd_set=1 -> done=1 at T0+7 with err=1; err stays 1 until the next accept edge.
- rst_n asserted in cycle 2 of PULSE -> S_bar returns to 1 asynchronously, no done pulse, cmd_ready=1 one edge after release.
- With SR_SKIP_REDUNDANT_EN defined, latch already at Q=1, cmd_set=1 -> no strobe pulse, done=1 at T0+1, err=0. Without the macro -> a full 4-cycle pulse, done at T0+7.
